// File: rtl/reg_desloc_arb_if.sv
// Requester-side handshake bundle for reg_desloc_arb.
// master = requester logic, slave = arbiter.
`timescale 1ns/1ps
interface reg_desloc_arb_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [1:0]       req_dir;
  logic             abort;
  logic [1:0]       req_ready;
  logic [1:0]       done;

  modport master (
    output req_valid,
    output req_data0,
    output req_data1,
    output req_dir,
    output abort,
    input  req_ready,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_data0,
    input  req_data1,
    input  req_dir,
    input  abort,
    output req_ready,
    output done
  );
endinterface

// File: rtl/reg_desloc_arb.sv
// Two-requester load/shift scheduler for reg_desloc.
// REG_DESLOC_ARB_RR_EN selects round-robin ties; else fixed priority.
`timescale 1ns/1ps
module reg_desloc_arb #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  reg_desloc_arb_if.slave  rq,
  output logic             busy,
  output logic             owner,
  output logic [CW-1:0]    shift_cnt,
  output logic [1:0]       op,
  output logic [WIDTH-1:0] parallel_in
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic       dir_q;
  logic       gnt;
  logic       tie_pick;
  logic       accept;
  logic [1:0] ready;
  logic       last_cnt;

`ifdef REG_DESLOC_ARB_RR_EN
  logic last_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_gnt <= 1'b1;
    else if (accept)
      last_gnt <= gnt;
  end

  assign tie_pick = ~last_gnt;
`else
  assign tie_pick = 1'b0;
`endif

  always_comb begin
    gnt = 1'b0;
    unique case (rq.req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = tie_pick;
      default: gnt = 1'b0;
    endcase
  end

  always_comb begin
    ready = 2'b00;
    if (state == IDLE)
      ready = rq.req_valid
            & (gnt ? 2'b10 : 2'b01);
  end

  assign accept       = |ready;
  assign rq.req_ready = ready;
  assign last_cnt     =
    (shift_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = LOAD;
      LOAD: state_nx = rq.abort ? IDLE : SHIFT;
      SHIFT: begin
        if (rq.abort)
          state_nx = IDLE;
        else if (last_cnt)
          state_nx = DONE;
      end
      DONE: state_nx = IDLE;
    endcase
  end

  // op/done/busy depend on the registered state only
  always_comb begin
    op      = 2'b00;
    rq.done = 2'b00;
    busy    = 1'b1;
    unique case (1'b1)
      (state == IDLE):  busy = 1'b0;
      (state == LOAD):  op = 2'b11;
      (state == SHIFT): op = dir_q ? 2'b10 : 2'b01;
      (state == DONE):
        rq.done = owner ? 2'b10 : 2'b01;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parallel_in <= '0;
      dir_q       <= 1'b0;
      owner       <= 1'b0;
    end else if (accept) begin
      parallel_in <= gnt ? rq.req_data1
                         : rq.req_data0;
      dir_q       <= rq.req_dir[gnt];
      owner       <= gnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      shift_cnt <= '0;
    else if (state == LOAD)
      shift_cnt <= '0;
    else if (state == SHIFT && !rq.abort)
      shift_cnt <= shift_cnt + 1'b1;
  end

endmodule

// File: tb/tb_reg_desloc_arb.sv
// Self-checking bench for reg_desloc_arb: vector table,
// directed corner sequences and a randomized reference model.
`timescale 1ns/1ps
module tb_reg_desloc_arb;
  localparam int W  = 4;
  localparam int CW = $clog2(W+1);
`ifdef REG_DESLOC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          busy;
  logic          owner;
  logic [CW-1:0] shift_cnt;
  logic [1:0]    op;
  logic [W-1:0]  pin;

  int n_cmp = 0;
  int n_err = 0;

  reg_desloc_arb_if #(.WIDTH(W)) bus ();

  reg_desloc_arb #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .rq          (bus),
    .busy        (busy),
    .owner       (owner),
    .shift_cnt   (shift_cnt),
    .op          (op),
    .parallel_in (pin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   v;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [1:0]   dir;
    logic [1:0]   rdy;
    logic [1:0]   op;
    logic [1:0]   dn;
    logic         bsy;
    logic         chk;
    logic         own;
    logic [W-1:0] pin;
    logic         cc;
    int           cnt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [1:0] v,
                       logic [W-1:0] d0,
                       logic [W-1:0] d1,
                       logic [1:0] dir,
                       logic ab);
    bus.req_valid = v;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    bus.req_dir   = dir;
    bus.abort     = ab;
  endtask

  task automatic do_reset();
    drive(2'b00, '0, '0, 2'b00, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic vec_t mk(
    logic [1:0] v, logic [W-1:0] d0,
    logic [W-1:0] d1, logic [1:0] dir,
    logic [1:0] rdy, logic [1:0] o,
    logic [1:0] dn, logic bsy, logic c,
    logic own, logic [W-1:0] p,
    logic cc, int cnt);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1;
    r.dir = dir; r.rdy = rdy; r.op = o;
    r.dn = dn; r.bsy = bsy; r.chk = c;
    r.own = own; r.pin = p;
    r.cc = cc; r.cnt = cnt;
    return r;
  endfunction

  // reference model state
  int         p;
  logic       m_own;
  logic       m_dir;
  logic [W-1:0] m_dat;
  logic       m_lg;

  function automatic logic [1:0] m_ready(
    int ph, logic [1:0] v, logic lg);
    if (ph != 0) return 2'b00;
    case (v)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return (RR && !lg) ? 2'b10
                                  : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] m_op(int ph);
    if (ph == 1) return 2'b11;
    if (ph >= 2 && ph <= W+1)
      return m_dir ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  initial begin
    int gi [4];
    int gt [4];
    int ng;
    int got;
    int cyc;
    logic [1:0] er;
    logic [1:0] v;

    drive(2'b00, '0, '0, 2'b00, 1'b0);
    reset = 1'b1;
    #12;
    chk("rst_op", op, 2'b00);
    chk("rst_pin", pin, 0);
    chk("rst_rdy", bus.req_ready, 2'b00);
    chk("rst_done", bus.done, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_cnt", shift_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    tbl[0]  = mk(2'b01, 4'hF, 4'h0, 2'b00,
                 2'b01, 2'b00, 2'b00, 0,
                 0, 0, 4'h0, 0, 0);
    tbl[1]  = mk(2'b00, 4'hF, 4'h0, 2'b00,
                 2'b00, 2'b11, 2'b00, 1,
                 1, 0, 4'hF, 0, 0);
    for (int i = 0; i < 4; i++)
      tbl[2+i] = mk(2'b00, 4'hF, 4'h0, 2'b00,
                    2'b00, 2'b01, 2'b00, 1,
                    1, 0, 4'hF, 1, i);
    tbl[6]  = mk(2'b00, 4'hF, 4'h0, 2'b00,
                 2'b00, 2'b00, 2'b01, 1,
                 1, 0, 4'hF, 1, 4);
    tbl[7]  = mk(2'b10, 4'h0, 4'hA, 2'b10,
                 2'b10, 2'b00, 2'b00, 0,
                 0, 0, 4'h0, 0, 0);
    tbl[8]  = mk(2'b00, 4'h0, 4'hA, 2'b10,
                 2'b00, 2'b11, 2'b00, 1,
                 1, 1, 4'hA, 0, 0);
    for (int i = 0; i < 4; i++)
      tbl[9+i] = mk(2'b00, 4'h0, 4'hA, 2'b10,
                    2'b00, 2'b10, 2'b00, 1,
                    1, 1, 4'hA, 1, i);
    tbl[13] = mk(2'b00, 4'h0, 4'hA, 2'b10,
                 2'b00, 2'b00, 2'b10, 1,
                 1, 1, 4'hA, 1, 4);
    tbl[14] = mk(2'b00, 4'h0, 4'h0, 2'b00,
                 2'b00, 2'b00, 2'b00, 0,
                 0, 0, 4'h0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].d0, tbl[i].d1,
            tbl[i].dir, 1'b0);
      #1;
      chk($sformatf("t%0d_rdy", i),
          bus.req_ready, tbl[i].rdy);
      chk($sformatf("t%0d_op", i),
          op, tbl[i].op);
      chk($sformatf("t%0d_done", i),
          bus.done, tbl[i].dn);
      chk($sformatf("t%0d_busy", i),
          busy, tbl[i].bsy);
      if (tbl[i].chk) begin
        chk($sformatf("t%0d_own", i),
            owner, tbl[i].own);
        chk($sformatf("t%0d_pin", i),
            pin, tbl[i].pin);
      end
      if (tbl[i].cc)
        chk($sformatf("t%0d_cnt", i),
            shift_cnt, tbl[i].cnt);
      step();
    end

    // tie: both valid continuously
    do_reset();
    drive(2'b11, 4'h5, 4'h9, 2'b00, 1'b0);
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        gi[ng] = bus.req_ready[1] ? 1 : 0;
        gt[ng] = c;
        chk("tie_onehot", bus.req_ready,
            gi[ng] ? 2'b10 : 2'b01);
        ng++;
      end
      step();
    end
    chk("tie_count", ng, 4);
    for (int k = 0; k < ng; k++) begin
      chk($sformatf("tie_gnt%0d", k), gi[k],
          RR ? (k % 2) : 0);
      if (k > 0)
        chk($sformatf("tie_gap%0d", k),
            gt[k] - gt[k-1], W+3);
    end
    drive(2'b00, '0, '0, 2'b00, 1'b0);
    repeat (W+3) step();

    // abort in second shift cycle
    do_reset();
    drive(2'b01, 4'h3, 4'h0, 2'b00, 1'b0);
    #1;
    chk("ab_rdy", bus.req_ready, 2'b01);
    step();
    drive(2'b00, 4'h3, 4'h0, 2'b00, 1'b0);
    step();
    step();
    chk("ab_sh2_op", op, 2'b01);
    chk("ab_sh2_cnt", shift_cnt, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_op", op, 2'b00);
    chk("ab_done", bus.done, 2'b00);
    drive(2'b10, 4'h0, 4'hC, 2'b10, 1'b0);
    #1;
    chk("ab_new_rdy", bus.req_ready, 2'b10);
    step();
    chk("ab_new_op", op, 2'b11);
    chk("ab_new_own", owner, 1);
    chk("ab_new_pin", pin, 4'hC);
    drive(2'b00, 4'h0, 4'hC, 2'b10, 1'b0);
    got = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done != 2'b00) begin
        chk("ab_new_done", bus.done, 2'b10);
        got++;
      end
      step();
    end
    chk("ab_done_cnt", got, 1);

    // async reset mid-shift
    do_reset();
    drive(2'b01, 4'h7, 4'h0, 2'b00, 1'b0);
    step();
    drive(2'b00, 4'h7, 4'h0, 2'b00, 1'b0);
    step();
    step();
    chk("ar_pre_busy", busy, 1);
    chk("ar_pre_op", op, 2'b01);
    #2;
    reset = 1'b1;
    #0.005;
    chk("ar_op", op, 2'b00);
    chk("ar_busy", busy, 0);
    chk("ar_pin", pin, 0);
    #0.005;
    reset = 1'b0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.done != 2'b00) got++;
    end
    chk("ar_no_done", got, 0);
    chk("ar_idle", busy, 0);

    // valid raised and dropped during shift
    do_reset();
    drive(2'b01, 4'h6, 4'h0, 2'b01, 1'b0);
    #1;
    chk("vd_rdy0", bus.req_ready, 2'b01);
    step();
    drive(2'b00, 4'h6, 4'h0, 2'b01, 1'b0);
    step();
    drive(2'b10, 4'h6, 4'hF, 2'b10, 1'b0);
    #1;
    chk("vd_rdy_sh", bus.req_ready, 2'b00);
    step();
    drive(2'b00, 4'h6, 4'hF, 2'b10, 1'b0);
    step();
    step();
    chk("vd_op", op, 2'b10);
    chk("vd_pin", pin, 4'h6);
    chk("vd_own", owner, 0);
    step();
    chk("vd_done", bus.done, 2'b01);
    chk("vd_pin_dn", pin, 4'h6);
    step();
    chk("vd_idle", busy, 0);
    chk("vd_rdy_end", bus.req_ready, 2'b00);

    // randomized run against the model
    do_reset();
    p = 0; m_own = 0; m_dir = 0;
    m_dat = '0; m_lg = 1'b1;
    v = 2'b00;
    cyc = 0;
    repeat (800) begin
      chk("r_op", op, m_op(p));
      chk("r_busy", busy, p != 0);
      chk("r_done", bus.done,
          (p == W+2) ? (m_own ? 2'b10 : 2'b01)
                     : 2'b00);
      if (p != 0) begin
        chk("r_own", owner, m_own);
        chk("r_pin", pin, m_dat);
      end
      if (p >= 2)
        chk("r_cnt", shift_cnt,
            (p == W+2) ? W : p-2);
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          if ($urandom_range(0, 4) == 0)
            v[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          if (i == 0)
            bus.req_data0 = W'($urandom);
          else
            bus.req_data1 = W'($urandom);
          bus.req_dir[i] = 1'($urandom);
        end
      end
      bus.req_valid = v;
      bus.abort = ($urandom_range(0, 9) == 0);
      #1;
      er = m_ready(p, v, m_lg);
      chk("r_rdy", bus.req_ready, er);
      step();
      if (p == 0) begin
        if (er != 2'b00) begin
          m_own = er[1];
          m_dat = er[1] ? bus.req_data1
                        : bus.req_data0;
          m_dir = bus.req_dir[er[1]];
          m_lg  = er[1];
          v[er[1]] = 1'b0;
          p = 1;
        end
      end else if (p <= W+1 && bus.abort) begin
        p = 0;
      end else if (p == W+2) begin
        p = 0;
      end else begin
        p++;
      end
      cyc++;
    end
    drive(2'b00, '0, '0, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_desloc_arb.md
# reg_desloc_arb

Two-requester scheduler for the 4-bit `reg_desloc` shift register. It accepts parallel words from two requesters over a valid/ready handshake and drives the register's `op` and `parallel_in`: one load cycle, then WIDTH shift cycles in the direction the requester chose. When the word is finished it pulses `done` to the owning requester. It sits between the requester logic and `reg_desloc` and is the only driver of `op` and `parallel_in`.

## Interface
- WIDTH, 4, shift register width in bits; legal range 2..16.
- CW, $clog2(WIDTH+1), width of `shift_cnt`; derived, do not override.

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  2  bit i: requester i presents a word.
- req_data0  in  WIDTH  word from requester 0.
- req_data1  in  WIDTH  word from requester 1.
- req_dir  in  2  bit i: 0 = shift right (op 01), 1 = shift left (op 10).
- abort  in  1  synchronous cancel of the current word.
- req_ready  out  2  accept strobe; at most one bit high.
- done  out  2  one-cycle completion pulse to the owner.
- busy  out  1  high in every state except IDLE.
- owner  out  1  index of the requester that owns the register; valid while busy.
- shift_cnt  out  CW  number of shifts completed for the current word.
- op  out  2  to `reg_desloc`: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- parallel_in  out  WIDTH  to `reg_desloc`: the captured word.

## Operation
The block is a four-state FSM: IDLE, LOAD, SHIFT, DONE.

**IDLE**
- `op` = 00.
- `req_ready` is combinational: the granted requester's bit follows its `req_valid` bit.
- A word is accepted on a cycle where `req_valid[i]` and `req_ready[i]` are both high. On that edge the block captures `req_data_i` into `parallel_in`, `req_dir[i]` into an internal direction register, and `i` into `owner`, then moves to LOAD.

**Grant rule**
- Only one requester valid: that requester is granted.
- Both valid: the requester that is not `last_gnt` is granted.
- `last_gnt` updates only on accept.

**LOAD**
- `op` = 11 for exactly one cycle.
- Next state is SHIFT; `shift_cnt` is cleared to 0.

**SHIFT**
- `op` = 01 if the captured direction is 0, otherwise 10.
- `shift_cnt` increments every cycle.
- After WIDTH shift cycles (`shift_cnt` reaches WIDTH-1 and then increments), the next state is DONE.

**DONE**
- `op` = 00; `done[owner]` = 1 for this one cycle.
- Next state is IDLE.

**Rules and boundary conditions**
- `op` is decoded from the registered state only, so it is glitch-free.
- Requests are not accepted outside IDLE; `req_ready` = 00 in LOAD, SHIFT and DONE.
- Requesters must hold `req_valid` and data stable until accepted. Dropping `req_valid` before accept is legal; nothing is captured.
- `abort` high in LOAD or SHIFT: next state is IDLE, with no `done` pulse and `last_gnt` kept. `abort` is ignored in IDLE and DONE.
- Reset mid-word: the block goes to IDLE immediately, `op` goes to 00 in the same instant, and any pending `done` is lost.

## Timing
- Reset values:
  - state = IDLE, `op` = 00, `parallel_in` = 0, `req_ready` = 00, `done` = 00
  - `busy` = 0, `owner` = 0, `shift_cnt` = 0, `last_gnt` = 1, so requester 0 wins the first tie.
- Accept at edge T:
  - LOAD in cycle T+1
  - SHIFT in cycles T+2 .. T+1+WIDTH
  - DONE in cycle T+2+WIDTH
  - IDLE in cycle T+3+WIDTH; earliest next accept at the end of that cycle.
- Throughput: one word per WIDTH+3 cycles; 7 cycles at WIDTH = 4.
- `parallel_in` is stable from LOAD through DONE.

## Configuration
- `REG_DESLOC_ARB_RR_EN` defined: the round-robin grant rule described above applies.
- Not defined: fixed priority.
  - Requester 0 always wins a tie.
  - `last_gnt` logic is removed.
  - All other behaviour and timing are identical.

## Test plan
1. Reset, then `req_valid` = 01, `req_data0` = 1111, `req_dir[0]` = 0. Required: `req_ready` = 01 for one cycle; `op` sequence 11, 01, 01, 01, 01, 00; `done` = 01 in cycle T+6; `busy` falls in cycle T+7.
2. Request 1 only, `req_data1` = 1010, `req_dir[1]` = 1. Required: `parallel_in` = 1010; four cycles of `op` = 10; `done` = 10; `owner` = 1 while busy.
3. Both requesters valid continuously (macro defined). Required: grants alternate 0, 1, 0, 1, each 7 cycles apart. Without the macro: requester 0 is granted every time.
4. `abort` pulsed at the second SHIFT cycle. Required: IDLE and `op` = 00 next cycle; no `done` pulse; a new accept is possible immediately after.
5. Async `reset` asserted for 10 ps mid-SHIFT. Required: `op` = 00 and `busy` = 0 without waiting for a clock edge; no `done` pulse.
6. `req_valid` raised and dropped during SHIFT. Required: no `req_ready` pulse and no capture; the current word completes unchanged.
